// File: rtl/axi_burst_addr_seq_if.sv
// Command and beat channels of the burst address sequencer.
// The slave modport is the sequencer's view; master is the view of whoever drives commands and takes beats.
interface axi_burst_addr_seq_if #(
  parameter int AW  = 32,
  parameter int IDW = 4,
  parameter int LEN = 8
);
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [AW-1:0]  i_cmd_addr;
  logic [LEN-1:0] i_cmd_len;
  logic [2:0]     i_cmd_size;
  logic [1:0]     i_cmd_burst;
  logic [IDW-1:0] i_cmd_id;
  logic           o_beat_valid;
  logic           i_beat_ready;
  logic [AW-1:0]  o_beat_addr;
  logic [IDW-1:0] o_beat_id;
  logic [LEN-1:0] o_beat_idx;
  logic           o_beat_last;
  logic           o_busy;
  logic           o_err_wrap;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst, i_cmd_id,
    input  i_beat_ready,
    output o_cmd_ready, o_beat_valid, o_beat_addr, o_beat_id, o_beat_idx,
    output o_beat_last, o_busy, o_err_wrap
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst, i_cmd_id,
    output i_beat_ready,
    input  o_cmd_ready, o_beat_valid, o_beat_addr, o_beat_id, o_beat_idx,
    input  o_beat_last, o_busy, o_err_wrap
  );
endinterface

// File: rtl/axi_burst_addr_seq.sv
// Expands one AXI address command into per-beat addresses (FIXED/INCR/WRAP),
// with a lookahead command accept on the last beat so bursts run back to back.
module axi_burst_addr_seq #(
  parameter int AW  = 32,
  parameter int IDW = 4,
  parameter int LEN = 8,
  parameter int ODW = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_burst_addr_seq_if.slave  bus
);

  localparam int ODWBYTES = ODW / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_addr;
  logic [LEN-1:0] r_idx;
  logic [LEN-1:0] r_len;
  logic [2:0]     r_size;
  logic [1:0]     r_burst;
  logic [IDW-1:0] r_id;
  logic           r_err;

  logic           w_cmd_ready;
  logic           w_beat_valid;
  logic           w_last;
  logic           w_accept;
  logic           w_wrap_len_ok;
  logic           w_illegal;
  logic [1:0]     w_burst_eff;
  logic [AW-1:0]  w_incr;
  logic [AW-1:0]  w_wrap_mask;
  logic [AW-1:0]  w_next_addr;

  assign w_last   = (r_state == BURST) && (r_idx == r_len);
  assign w_accept = bus.i_cmd_valid && w_cmd_ready;

  assign w_wrap_len_ok = (bus.i_cmd_len == LEN'(1)) || (bus.i_cmd_len == LEN'(3)) ||
                         (bus.i_cmd_len == LEN'(7)) || (bus.i_cmd_len == LEN'(15));
  assign w_illegal   = (bus.i_cmd_burst == 2'b11) ||
                       ((bus.i_cmd_burst == BURST_WRAP) && !w_wrap_len_ok);
  assign w_burst_eff = w_illegal ? BURST_INCR : bus.i_cmd_burst;

  // Next-address arithmetic uses registered command state only.
  always_comb begin
    w_incr = AW'(1) << r_size;
    if (w_incr > AW'(ODWBYTES)) begin
      w_incr = AW'(ODWBYTES);
    end
    w_wrap_mask = ((AW'(r_len) + AW'(1)) * w_incr) - AW'(1);
    case (r_burst)
      BURST_FIXED: w_next_addr = r_addr;
      BURST_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_incr) & w_wrap_mask);
      default:     w_next_addr = (r_addr + w_incr) & ~(w_incr - AW'(1));
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_ready  = 1'b0;
    w_beat_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.i_cmd_valid) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_beat_valid = 1'b1;
        w_cmd_ready  = w_last && bus.i_beat_ready;
        if (w_last && bus.i_beat_ready && !bus.i_cmd_valid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new command wins over beat advance; this is what gives the zero-bubble handover.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_accept) begin
        r_addr  <= bus.i_cmd_addr;
        r_idx   <= '0;
        r_len   <= bus.i_cmd_len;
        r_size  <= bus.i_cmd_size;
        r_burst <= w_burst_eff;
        r_id    <= bus.i_cmd_id;
      end else if (w_beat_valid && bus.i_beat_ready && !w_last) begin
        r_addr <= w_next_addr;
        r_idx  <= r_idx + LEN'(1);
      end
    end
  end

  assign bus.o_cmd_ready  = w_cmd_ready;
  assign bus.o_beat_valid = w_beat_valid;
  assign bus.o_beat_addr  = r_addr;
  assign bus.o_beat_id    = r_id;
  assign bus.o_beat_idx   = r_idx;
  assign bus.o_beat_last  = w_last;
  assign bus.o_busy       = (r_state == BURST);
  assign bus.o_err_wrap   = r_err;

endmodule

// File: doc/axi_burst_addr_seq.md
Name: axi_burst_addr_seq

Overview:
Accepts one AXI address-channel command (addr/len/size/burst/id) and expands it into a stream of per-beat addresses, one beat per output handshake. It applies FIXED/INCR/WRAP next-address arithmetic, clamping the increment to the output data width. It sits between an AR or AW skid buffer and the read/write data-path engines of an AXI slave or width converter. A registered output and a lookahead command accept allow back-to-back bursts with no idle cycle.

Parameters:
AW, 32, address width
IDW, 4, transaction ID width
LEN, 8, burst length field width
ODW, 32, output data-path width in bits; ODWBYTES = ODW/8

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command accepted when valid&ready
i_cmd_addr  input  AW  burst start address
i_cmd_len  input  LEN  beats minus one
i_cmd_size  input  3  log2 bytes per beat
i_cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
i_cmd_id  input  IDW  transaction ID
o_beat_valid  output  1  beat valid
i_beat_ready  input  1  beat consumed when valid&ready
o_beat_addr  output  AW  address of current beat
o_beat_id  output  IDW  ID of owning burst
o_beat_idx  output  LEN  beat index, 0-based
o_beat_last  output  1  final beat of burst
o_busy  output  1  a burst is in progress
o_err_wrap  output  1  one-cycle pulse: illegal WRAP length or reserved burst type accepted

Behaviour:
- Clock and reset: single clock aclk; reset aresetn is asynchronous and active-low. Reset clears all state, state=IDLE, and drives every output to 0 except o_cmd_ready, which is combinational and equals 1 in IDLE.
- States:
  - IDLE: o_beat_valid=0 and o_cmd_ready=1. An accepted command loads the registers and moves to BURST.
  - BURST: o_beat_valid=1.
- Latency: the first beat is presented on the cycle after command acceptance; each beat lasts exactly one cycle when i_beat_ready=1.
- Beat handshake in BURST:
  - If valid&ready and not last: o_beat_idx+=1 and o_beat_addr<=next_addr.
  - If valid&ready and last: return to IDLE, unless a command is accepted in the same cycle.
- Lookahead accept: o_cmd_ready = IDLE | (BURST & o_beat_last & i_beat_ready). A command accepted on the last-beat handshake loads directly, stays in BURST, and gives zero bubble.
- Stall: o_beat_addr, o_beat_idx, o_beat_last and o_beat_id stay stable while valid & !ready.
- o_beat_last = (o_beat_idx == stored len).
- o_busy = (state == BURST).
- Increment arithmetic: incr = min(1<<size, ODWBYTES). Computed at AW bits with unsigned wrap-around at 2^AW; no 4 KB boundary checking.
- Next-address rules:
  - FIXED: next_addr = current address.
  - INCR: next_addr = (cur + incr) & ~(incr-1). This aligns an unaligned start on the second beat.
  - WRAP: wrap_bytes = (len+1)*incr and mask = wrap_bytes-1. next_addr = (cur & ~mask) | ((cur+incr) & mask).
- Illegal commands:
  - WRAP with len not in {1,3,7,15}: treated as INCR, and o_err_wrap pulses the cycle after acceptance.
  - Burst=11: treated as INCR, with the same pulse.
- len=0: a single beat with o_beat_last=1 immediately.
- Reset mid-burst: the burst is abandoned at once. No partial beat survives, and o_beat_valid=0 while aresetn=0.
- Storage: the command, the current address and the counter are registered. The next-address logic is combinational from registered state only, with no combinational path from i_cmd_* to o_beat_*.

Test Plan:
- INCR, addr=0x1000, len=3, size=2, ODW=32, ready=1 -> beats 0x1000, 0x1004, 0x1008, 0x100C; last on idx 3; 4 consecutive cycles.
- WRAP, addr=0x1008, len=3, size=2 -> beats 0x1008, 0x100C, 0x1000, 0x1004; last on the 4th beat; o_err_wrap=0.
- FIXED, addr=0x2000, len=2, with i_beat_ready toggling 1,0,1,0,1 -> addr is 0x2000 on all 3 beats; outputs held during stalls; o_busy drops after the 3rd handshake.
- Back-to-back: second command (INCR 0x3000, len=0) valid during the last beat of the first -> o_cmd_ready=1 on that cycle; 0x3000 beat appears the next cycle, no gap, last=1.
- Illegal WRAP len=2, addr=0x10, size=2 -> INCR beats 0x10, 0x14, 0x18; o_err_wrap is a 1-cycle pulse.
- Reset mid-burst: assert aresetn=0 after 2 beats of a len=7 burst -> o_beat_valid=0 immediately; after release, IDLE with o_cmd_ready=1. INCR start 0xFFFFFFFC, size=2, len=1 -> beats 0xFFFFFFFC, 0x00000000.
